// File: rtl/axi_stream_if.sv
// AXI-Stream style byte channel shared by the TCP receive path.
// Ports: tdata/tvalid/tlast/tuser driven by master, tready by slave.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/tcp_segment_parser.sv
// Strips the TCP header (and options) from a byte stream, forwarding payload.
// Ports: clk, rst (sync, active-high); s_axis segment bytes in; m_axis payload
// out; seq_start/seq_base sequence info; base_valid/fin_seen/hdr_err pulses.
module tcp_segment_parser #(
    parameter int DATA_WIDTH = 8,
    parameter int SEQ_BITS   = 32
) (
    input  logic                clk,
    input  logic                rst,
    axi_stream_if.slave         s_axis,
    axi_stream_if.master        m_axis,
    output logic [SEQ_BITS-1:0] seq_start,
    output logic [SEQ_BITS-1:0] seq_base,
    output logic                base_valid,
    output logic                fin_seen,
    output logic                hdr_err
);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_OPT,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [31:0]         seq_raw_q, seq_raw_d;
    logic [3:0]          doff_q, doff_d;
    logic                flag_rst_q, flag_rst_d;
    logic                flag_syn_q, flag_syn_d;
    logic                flag_fin_q, flag_fin_d;
    logic [SEQ_BITS-1:0] seq_start_q, seq_start_d;
    logic [SEQ_BITS-1:0] seq_base_q, seq_base_d;
    logic                base_valid_q, base_valid_d;
    logic                fin_seen_q, fin_seen_d;
    logic                hdr_err_q, hdr_err_d;

    logic       accept;
    logic       hdr_last;
    logic [5:0] opt_end;
    logic       unused_tuser;

    assign unused_tuser = s_axis.tuser;

    // Header bytes are swallowed; payload is a pure wire path so it adds
    // no latency and backpressure flows straight through.
    always_comb begin
        m_axis.tdata = s_axis.tdata;
        m_axis.tuser = 1'b0;
        if (!rst && state_q == ST_PAYLOAD) begin
            m_axis.tvalid = s_axis.tvalid;
            m_axis.tlast  = s_axis.tlast;
            s_axis.tready = m_axis.tready;
        end else begin
            m_axis.tvalid = 1'b0;
            m_axis.tlast  = 1'b0;
            s_axis.tready = 1'b1;
        end
    end

    assign accept  = s_axis.tvalid & s_axis.tready;
    // Index of the final option byte: header length in bytes minus one.
    assign opt_end = {doff_q, 2'b00} - 6'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seq_raw_d    = seq_raw_q;
        doff_d       = doff_q;
        flag_rst_d   = flag_rst_q;
        flag_syn_d   = flag_syn_q;
        flag_fin_d   = flag_fin_q;
        seq_start_d  = seq_start_q;
        seq_base_d   = seq_base_q;
        base_valid_d = 1'b0;
        fin_seen_d   = 1'b0;
        hdr_err_d    = 1'b0;
        hdr_last     = 1'b0;

        unique case (state_q)
            ST_HDR: begin
                if (accept) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q inside {[6'd4:6'd7]}) begin
                        seq_raw_d = {seq_raw_q[31-DATA_WIDTH:0],
                                     s_axis.tdata};
                    end
                    if (cnt_q == 6'd12) begin
                        doff_d = s_axis.tdata[7:4];
                    end
                    if (cnt_q == 6'd13) begin
                        flag_rst_d = s_axis.tdata[2];
                        flag_syn_d = s_axis.tdata[1];
                        flag_fin_d = s_axis.tdata[0];
                    end
                    if (cnt_q == 6'd12 && s_axis.tdata[7:4] < 4'd5) begin
                        hdr_err_d = 1'b1;
                        cnt_d     = 6'd0;
                        state_d   = s_axis.tlast ? ST_HDR : ST_DROP;
                    end else if (cnt_q == 6'd19) begin
                        if (doff_q == 4'd5) begin
                            hdr_last = 1'b1;
                        end else if (s_axis.tlast) begin
                            hdr_err_d = 1'b1;
                            cnt_d     = 6'd0;
                        end else begin
                            state_d = ST_OPT;
                        end
                    end else if (s_axis.tlast) begin
                        // Segment ended inside the fixed header.
                        hdr_err_d = 1'b1;
                        cnt_d     = 6'd0;
                    end
                end
            end
            ST_OPT: begin
                if (accept) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == opt_end) begin
                        hdr_last = 1'b1;
                    end else if (s_axis.tlast) begin
                        hdr_err_d = 1'b1;
                        cnt_d     = 6'd0;
                        state_d   = ST_HDR;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept && s_axis.tlast) begin
                    fin_seen_d = flag_fin_q;
                    cnt_d      = 6'd0;
                    state_d    = ST_HDR;
                end
            end
            ST_DROP: begin
                if (accept && s_axis.tlast) begin
                    cnt_d   = 6'd0;
                    state_d = ST_HDR;
                end
            end
            default: begin
                cnt_d   = 6'd0;
                state_d = ST_HDR;
            end
        endcase

        // Common wrap-up once the full header (incl. options) is consumed.
        if (hdr_last) begin
            cnt_d       = 6'd0;
            seq_start_d = SEQ_BITS'(seq_raw_q)
                        + {{(SEQ_BITS-1){1'b0}}, flag_syn_q};
            if (flag_rst_q) begin
                state_d = s_axis.tlast ? ST_HDR : ST_DROP;
            end else begin
                if (flag_syn_q) begin
                    base_valid_d = 1'b1;
                    seq_base_d   = SEQ_BITS'(seq_raw_q)
                                 + {{(SEQ_BITS-1){1'b0}}, 1'b1};
                end
                fin_seen_d = s_axis.tlast & flag_fin_q;
                state_d    = s_axis.tlast ? ST_HDR : ST_PAYLOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HDR;
            cnt_q        <= 6'd0;
            seq_raw_q    <= 32'd0;
            doff_q       <= 4'd0;
            flag_rst_q   <= 1'b0;
            flag_syn_q   <= 1'b0;
            flag_fin_q   <= 1'b0;
            seq_start_q  <= '0;
            seq_base_q   <= '0;
            base_valid_q <= 1'b0;
            fin_seen_q   <= 1'b0;
            hdr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seq_raw_q    <= seq_raw_d;
            doff_q       <= doff_d;
            flag_rst_q   <= flag_rst_d;
            flag_syn_q   <= flag_syn_d;
            flag_fin_q   <= flag_fin_d;
            seq_start_q  <= seq_start_d;
            seq_base_q   <= seq_base_d;
            base_valid_q <= base_valid_d;
            fin_seen_q   <= fin_seen_d;
            hdr_err_q    <= hdr_err_d;
        end
    end

    assign seq_start  = seq_start_q;
    assign seq_base   = seq_base_q;
    assign base_valid = base_valid_q;
    assign fin_seen   = fin_seen_q;
    assign hdr_err    = hdr_err_q;

endmodule

// File: tb/tb_tcp_segment_parser.sv
// Scoreboard bench for tcp_segment_parser: directed segments in,
// expected payload beats and status pulses checked by a monitor.
module tb_tcp_segment_parser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_stream_if #(.DATA_WIDTH(8)) s_if ();
    axi_stream_if #(.DATA_WIDTH(8)) m_if ();

    logic [31:0] seq_start;
    logic [31:0] seq_base;
    logic        base_valid;
    logic        fin_seen;
    logic        hdr_err;

    tcp_segment_parser #(.DATA_WIDTH(8), .SEQ_BITS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .seq_start  (seq_start),
        .seq_base   (seq_base),
        .base_valid (base_valid),
        .fin_seen   (fin_seen),
        .hdr_err    (hdr_err)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic        l;
        logic [31:0] ss;
    } beat_t;

    typedef struct packed {
        logic [1:0]  k;
        logic [31:0] v;
    } evt_t;

    localparam logic [1:0] K_BASE = 2'd0;
    localparam logic [1:0] K_FIN  = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    beat_t exp_beats[$];
    evt_t  exp_evts[$];
    int    checks   = 0;
    int    failures = 0;
    bit    toggle_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void check_evt(logic [1:0] k, logic [31:0] v);
        evt_t e;
        if (exp_evts.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: got kind %0d expected none", k);
        end else begin
            e = exp_evts.pop_front();
            chk("pulse_kind", 32'(k), 32'(e.k));
            if (k == K_BASE) chk("seq_base", v, e.v);
        end
    endfunction

    // Downstream ready: constant 1 or toggling every cycle.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = toggle_en ? ~m_if.tready : 1'b1;
        end
    end

    // Monitor: inputs only change just after posedge, so values at the
    // negedge are exactly what the next posedge will sample.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_if.tvalid) chk("stall", 32'(s_if.tready), 32'(m_if.tready));
            if (m_if.tvalid && m_if.tready) begin
                beat_t e;
                if (exp_beats.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat: got data %h expected none",
                             m_if.tdata);
                end else begin
                    e = exp_beats.pop_front();
                    chk("beat_data", 32'(m_if.tdata), 32'(e.d));
                    chk("beat_last", 32'(m_if.tlast), 32'(e.l));
                    chk("seq_start", seq_start, e.ss);
                    chk("tuser", 32'(m_if.tuser), 32'd0);
                end
            end
            if (base_valid) check_evt(K_BASE, seq_base);
            if (fin_seen)   check_evt(K_FIN, 32'd0);
            if (hdr_err)    check_evt(K_ERR, 32'd0);
        end
    end

    task automatic drive_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        forever begin
            @(negedge clk);
            if (s_if.tready) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL tready_timeout: got 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // cut >= 0 forces tlast at that byte index.
    task automatic send_seg(input logic [31:0] seq, input logic [7:0] b12,
                            input logic [7:0] flags, input int plen,
                            input logic [7:0] seed, input int cut);
        int hl;
        int len;
        hl  = 4 * int'(b12[7:4]);
        len = (cut >= 0) ? cut + 1 : hl + plen;
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            if (i < 4)        b = 8'h12 + 8'(i);
            else if (i < 8)   b = seq[8*(7-i) +: 8];
            else if (i < 12)  b = 8'h00;
            else if (i == 12) b = b12;
            else if (i == 13) b = flags;
            else if (i < 20)  b = 8'hA5;
            else if (i < hl)  b = 8'h01;
            else              b = seed + 8'(i - hl);
            drive_byte(b, i == len - 1);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic push_payload(input logic [7:0] seed, input int n,
                                input logic [31:0] ss);
        for (int i = 0; i < n; i++) begin
            exp_beats.push_back('{d: seed + 8'(i), l: (i == n - 1), ss: ss});
        end
    endtask

    task automatic push_evt(input logic [1:0] k, input logic [31:0] v);
        exp_evts.push_back('{k: k, v: v});
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 32'(s_if.tready), 32'd1);
        chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_tlast", 32'(m_if.tlast), 32'd0);
        chk("rst_seq_start", seq_start, 32'd0);
        chk("rst_seq_base", seq_base, 32'd0);
        chk("rst_pulses", {29'd0, base_valid, fin_seen, hdr_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SYN, no payload
        push_evt(K_BASE, 32'h0000_1000);
        send_seg(32'h0000_0FFF, 8'h50, 8'h02, 0, 8'h00, -1);

        // 12 option bytes + 16 payload bytes
        push_payload(8'h40, 16, 32'h0000_1010);
        send_seg(32'h0000_1010, 8'h80, 8'h10, 16, 8'h40, -1);

        // same segment with toggling backpressure
        toggle_en = 1'b1;
        push_payload(8'h60, 16, 32'h0000_1010);
        send_seg(32'h0000_1010, 8'h80, 8'h10, 16, 8'h60, -1);
        toggle_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // doff 3: dropped, then a good FIN segment
        push_evt(K_ERR, 32'd0);
        send_seg(32'h0000_2000, 8'h30, 8'h10, 18, 8'h00, -1);
        push_payload(8'h80, 5, 32'h0000_3000);
        push_evt(K_FIN, 32'd0);
        send_seg(32'h0000_3000, 8'h50, 8'h11, 5, 8'h80, -1);

        // tlast at byte 10
        push_evt(K_ERR, 32'd0);
        send_seg(32'h0000_4000, 8'h50, 8'h10, 10, 8'h00, 10);

        // SYN wraps to zero
        push_evt(K_BASE, 32'h0000_0000);
        send_seg(32'hFFFF_FFFF, 8'h50, 8'h02, 0, 8'h00, -1);

        // SYN with payload: data starts at seq+1
        push_evt(K_BASE, 32'h0000_0501);
        push_payload(8'hC0, 3, 32'h0000_0501);
        send_seg(32'h0000_0500, 8'h50, 8'h02, 3, 8'hC0, -1);

        // RST segment: nothing at all
        send_seg(32'h0000_6000, 8'h50, 8'h04, 8, 8'h11, -1);

        // tlast inside options
        push_evt(K_ERR, 32'd0);
        send_seg(32'h0000_7000, 8'h70, 8'h10, 0, 8'h00, 22);

        // FIN with options, zero payload
        push_evt(K_FIN, 32'd0);
        send_seg(32'h0000_7100, 8'h60, 8'h11, 0, 8'h00, -1);

        // reset mid-header, then a clean segment
        for (int i = 0; i < 8; i++) drive_byte(8'h33, 1'b0);
        s_if.tvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_payload(8'h90, 4, 32'h0000_8000);
        send_seg(32'h0000_8000, 8'h50, 8'h10, 4, 8'h90, -1);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("beats_left", 32'(exp_beats.size()), 32'd0);
        chk("evts_left", 32'(exp_evts.size()), 32'd0);
        chk("seq_start_final", seq_start, 32'h0000_8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcp_segment_parser.md
TCP_SEGMENT_PARSER -- requirements
Module: tcp_segment_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 8, stream beat width; only 8 is supported (one byte per beat).
REQ-002 Parameter SEQ_BITS, default 32, width of sequence outputs.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_axis  axi_stream_if slave  DATA_WIDTH  TCP segment bytes, byte 0 = first TCP header byte, tlast on final segment byte.
REQ-006 m_axis  axi_stream_if master  DATA_WIDTH  payload bytes only, tlast on final payload byte; feeds reorder buffer s_axis.
REQ-007 seq_start  output  SEQ_BITS  absolute sequence number of the first payload byte of the current segment.
REQ-008 seq_base  output  SEQ_BITS  initial receive sequence (SYN seq + 1).
REQ-009 base_valid  output  1  one-cycle pulse qualifying seq_base.
REQ-010 fin_seen  output  1  one-cycle pulse, segment with FIN flag fully parsed.
REQ-011 hdr_err  output  1  one-cycle pulse, segment dropped as malformed.

Function
REQ-012 FSM states: HDR (fixed 20-byte header), OPT (options), PAYLOAD, DROP; 6-bit byte counter cnt.
REQ-013 HDR/OPT/DROP: s_axis.tready = 1, m_axis.tvalid = 0; header bytes never appear on m_axis.
REQ-014 HDR: capture bytes 4..7 big-endian as seq_raw, byte 12 bits[7:4] as doff, byte 13 bits {RST=2, SYN=1, FIN=0}.
REQ-015 On acceptance of byte 12 with doff < 5: hdr_err pulse next cycle, go to DROP (or HDR if that byte has tlast).
REQ-016 On acceptance of byte 19: doff = 5 -> PAYLOAD; doff > 5 -> OPT, skipping exactly 4*doff-20 option bytes (max 40).
REQ-017 seq_start = seq_raw + SYN (mod 2^SEQ_BITS), registered on acceptance of the last header byte; stable until next segment's last header byte.
REQ-018 SYN=1 and RST=0: base_valid pulses the cycle after the last header byte is accepted, seq_base = seq_raw + 1 (mod 2^SEQ_BITS, 0xFFFFFFFF -> 0x00000000); seq_base held until next SYN.
REQ-019 RST=1: segment dropped entirely (no payload, no base_valid, no fin_seen), no hdr_err.
REQ-020 PAYLOAD: combinational pass-through, m_axis.tdata/tvalid/tlast = s_axis fields, s_axis.tready = m_axis.tready; m_axis.tuser = 0.
REQ-021 m_axis.tvalid shall not depend on m_axis.tready; backpressure stalls s_axis with no byte lost or duplicated.
REQ-022 PAYLOAD -> HDR on accepted beat with tlast; cnt cleared.
REQ-023 tlast on the last header/option byte: zero-length payload, no m_axis beat, return to HDR; SYN/FIN pulses still produced.
REQ-024 tlast accepted before header (incl. options) complete: hdr_err pulse, return to HDR, no other pulse.
REQ-025 DROP: discard bytes until accepted tlast, then HDR.
REQ-026 fin_seen pulses the cycle after the segment's final byte is accepted, only for non-dropped segments.
REQ-027 Zero added latency on payload; header parse costs one cycle per header byte, no bubble between segments.

Reset
REQ-028 On rst: state HDR, cnt 0, seq_start 0, seq_base 0, base_valid 0, fin_seen 0, hdr_err 0, m_axis.tvalid 0, m_axis.tlast 0, s_axis.tready 1.
REQ-029 Reset mid-segment: parser restarts at HDR; partial segment is not tracked, and upstream is reset together with this block.
REQ-030 rst has priority over any simultaneous handshake that cycle.

Verification
REQ-031 SYN, seq 0x00000FFF, doff 5, no payload -> base_valid 1 cycle, seq_base 0x00001000, no m_axis beats.
REQ-032 seq 0x00001010, doff 8 (12 option bytes), 16-byte payload, tready=1 -> seq_start 0x00001010 before first beat, exactly 16 m_axis beats, tlast on 16th, data identical.
REQ-033 Same segment, m_axis.tready toggling 1/0 each cycle -> same 16 bytes in order, s_axis stalled on tready=0 cycles.
REQ-034 Byte 12 = 0x30 (doff 3), 30-byte segment -> hdr_err pulse, zero m_axis beats, next valid segment parsed correctly.
REQ-035 Segment with tlast at byte 10 -> hdr_err pulse, HDR; SYN seq 0xFFFFFFFF -> seq_base 0x00000000.
REQ-036 End-to-end: 200-byte message split into 8-32 byte segments with 20-byte headers, shuffled, through this block into tcp_reorder_buffer (base from leading SYN) -> 200 output bytes match message.
